// File: rtl/ted_loop_ctrl.sv
// ted_loop_ctrl: timing-recovery loop controller around the ML timing error detector.
// Counts oversampled samples, strobes the TED on the selected on-time phase, runs the
// TED error through a PI loop filter (acquisition/tracking gains) and slips the
// sampling phase by one sample whenever the filter output crosses the threshold.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | loop stopped, no strobes, TED error ignored
// ST_ACQ   | acquisition: wide-gain filter, counting strobes toward tracking
// ST_TRACK | tracking: narrow-gain filter, slip-free strobes counted for lock

module ted_loop_ctrl #(
  parameter int NB_TED    = 19,
  parameter int NB_ACC    = 24,
  parameter int OS        = 4,
  parameter int KP_SH_ACQ = 4,
  parameter int KI_SH_ACQ = 8,
  parameter int KP_SH_TRK = 6,
  parameter int KI_SH_TRK = 12,
  parameter int THRESH    = 2048,
  parameter int ACQ_SYMS  = 256,
  parameter int LOCK_SYMS = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_start,
  input  logic                     i_stop,
  input  logic                     i_sample_valid,
  input  logic signed [NB_TED-1:0] i_ted,
  input  logic                     i_ted_valid,
  output logic                     o_enable_ted,
  output logic [$clog2(OS)-1:0]    o_phase_sel,
  output logic [1:0]               o_state,
  output logic                     o_locked,
  output logic                     o_slip_adv,
  output logic                     o_slip_ret,
  output logic signed [NB_ACC-1:0] o_loop_out
);

  localparam int PW  = $clog2(OS);
  localparam int NW  = NB_ACC + 2;
  localparam int ACW = $clog2(ACQ_SYMS + 1);
  localparam int LCW = $clog2(LOCK_SYMS + 1);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ACQ   = 2'b01;
  localparam logic [1:0] ST_TRACK = 2'b10;

  localparam logic [PW-1:0]  LP_PH_MAX    = PW'(OS - 1);
  localparam logic [PW-1:0]  LP_INH_LOAD  = PW'(OS - 2);
  localparam logic [ACW-1:0] LP_ACQ_LOAD  = ACW'(ACQ_SYMS - 1);
  localparam logic [LCW-1:0] LP_LOCK_LOAD = LCW'(LOCK_SYMS - 1);

  localparam logic signed [NW-1:0] LP_SAT_MAX = NW'((64'sd1 <<< (NB_ACC - 1)) - 64'sd1);
  localparam logic signed [NW-1:0] LP_SAT_MIN = -LP_SAT_MAX;
  localparam logic signed [NW-1:0] LP_THR     = NW'(THRESH);

  // Registers
  logic [1:0]               r_state;
  logic [PW-1:0]            r_samp_cnt;
  logic [PW-1:0]            r_phase;
  logic [PW-1:0]            r_inhibit;
  logic [ACW-1:0]           r_acq_cnt;
  logic [LCW-1:0]           r_lock_cnt;
  logic                     r_locked;
  logic                     r_enable_ted;
  logic                     r_slip_adv;
  logic                     r_slip_ret;
  logic signed [NB_ACC-1:0] r_integ;
  logic signed [NB_ACC-1:0] r_loop_out;

  // Combinational
  logic                     w_active;
  logic                     w_abort;
  logic                     w_go;
  logic                     w_sample;
  logic                     w_strobe;
  logic                     w_upd;
  logic                     w_slip_adv;
  logic                     w_slip_ret;
  logic [PW-1:0]            w_samp_nxt;
  logic [PW-1:0]            w_phase_inc;
  logic [PW-1:0]            w_phase_dec;
  logic signed [NB_ACC-1:0] w_e;
  logic signed [NB_ACC-1:0] w_kp_term;
  logic signed [NB_ACC-1:0] w_ki_term;
  logic signed [NB_ACC-1:0] w_integ_sum;
  logic signed [NB_ACC-1:0] w_out;
  logic signed [NB_ACC-1:0] w_integ_nxt;
  logic                     w_over;
  logic                     w_under;

  // Sign-extend an accumulator value into the guard-bit width used for sums.
  function automatic logic signed [NW-1:0] f_ext(input logic signed [NB_ACC-1:0] v);
    return {{2{v[NB_ACC-1]}}, v};
  endfunction

  // Symmetric clamp to +/-(2^(NB_ACC-1)-1); the most negative code is never produced.
  function automatic logic signed [NB_ACC-1:0] f_sat(input logic signed [NW-1:0] v);
    if (v > LP_SAT_MAX) begin
      return LP_SAT_MAX[NB_ACC-1:0];
    end else if (v < LP_SAT_MIN) begin
      return LP_SAT_MIN[NB_ACC-1:0];
    end else begin
      return v[NB_ACC-1:0];
    end
  endfunction

  // Control qualifiers: stop beats everything, start only counts from IDLE without stop.
  always_comb begin
    w_active   = (r_state == ST_ACQ) || (r_state == ST_TRACK);
    w_abort    = w_active && i_stop;
    w_go       = (r_state == ST_IDLE) && i_start && !i_stop;
    w_sample   = w_active && !i_stop && i_sample_valid;
    w_strobe   = w_sample && (r_samp_cnt == r_phase) && (r_inhibit == '0);
    w_upd      = w_active && !i_stop && i_ted_valid;
    w_slip_adv = w_upd && w_over;
    w_slip_ret = w_upd && w_under;
  end

  // Modulo-OS increment/decrement for the sample counter and phase index.
  always_comb begin
    w_samp_nxt  = (r_samp_cnt == LP_PH_MAX) ? '0 : r_samp_cnt + 1'b1;
    w_phase_inc = (r_phase == LP_PH_MAX) ? '0 : r_phase + 1'b1;
    w_phase_dec = (r_phase == '0) ? LP_PH_MAX : r_phase - 1'b1;
  end

  // PI loop filter with state-selected gains and the slip decision.
  always_comb begin
    w_e = NB_ACC'(i_ted);
    if (r_state == ST_TRACK) begin
      w_kp_term = w_e >>> KP_SH_TRK;
      w_ki_term = w_e >>> KI_SH_TRK;
    end else begin
      w_kp_term = w_e >>> KP_SH_ACQ;
      w_ki_term = w_e >>> KI_SH_ACQ;
    end
    w_integ_sum = f_sat(f_ext(r_integ) + f_ext(w_ki_term));
    w_out       = f_sat(f_ext(w_kp_term) + f_ext(w_integ_sum));
    w_over      = f_ext(w_out) > LP_THR;
    w_under     = f_ext(w_out) < -LP_THR;
    // A slip moves the sampling instant by one sample, so the integrator gives
    // back one threshold's worth of accumulated error in the same direction.
    if (w_over) begin
      w_integ_nxt = f_sat(f_ext(w_integ_sum) - LP_THR);
    end else if (w_under) begin
      w_integ_nxt = f_sat(f_ext(w_integ_sum) + LP_THR);
    end else begin
      w_integ_nxt = w_integ_sum;
    end
  end

  // State machine with ACQ strobe budget and TRACK slip-free lock timer (down-counters).
  always_ff @(posedge clk) begin
    if (!rst_n || w_abort) begin
      r_state    <= ST_IDLE;
      r_acq_cnt  <= '0;
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_go) begin
            r_state   <= ST_ACQ;
            r_acq_cnt <= LP_ACQ_LOAD;
          end
        end
        ST_ACQ: begin
          if (w_strobe) begin
            if (r_acq_cnt == '0) begin
              r_state    <= ST_TRACK;
              r_lock_cnt <= LP_LOCK_LOAD;
            end else begin
              r_acq_cnt <= r_acq_cnt - 1'b1;
            end
          end
        end
        ST_TRACK: begin
          if (w_slip_adv || w_slip_ret) begin
            r_lock_cnt <= LP_LOCK_LOAD;
            r_locked   <= 1'b0;
          end else if (w_strobe) begin
            if (r_lock_cnt == '0) begin
              r_locked <= 1'b1;
            end else begin
              r_lock_cnt <= r_lock_cnt - 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sample counter, strobe generation with post-strobe inhibit, and phase slips.
  always_ff @(posedge clk) begin
    if (!rst_n || w_abort || w_go) begin
      r_samp_cnt   <= '0;
      r_phase      <= '0;
      r_inhibit    <= '0;
      r_enable_ted <= 1'b0;
    end else begin
      r_enable_ted <= w_strobe;
      if (w_sample) begin
        r_samp_cnt <= w_samp_nxt;
      end
      // Inhibit keeps a wrapped advance from firing a second strobe OS-1 samples early.
      if (w_strobe) begin
        r_inhibit <= LP_INH_LOAD;
      end else if (w_sample && (r_inhibit != '0)) begin
        r_inhibit <= r_inhibit - 1'b1;
      end
      if (w_slip_adv) begin
        r_phase <= w_phase_inc;
      end else if (w_slip_ret) begin
        r_phase <= w_phase_dec;
      end
    end
  end

  // Loop-filter registers and one-cycle slip pulses.
  always_ff @(posedge clk) begin
    if (!rst_n || w_abort || w_go) begin
      r_integ    <= '0;
      r_loop_out <= '0;
      r_slip_adv <= 1'b0;
      r_slip_ret <= 1'b0;
    end else begin
      r_slip_adv <= w_slip_adv;
      r_slip_ret <= w_slip_ret;
      if (w_upd) begin
        r_integ    <= w_integ_nxt;
        r_loop_out <= w_out;
      end
    end
  end

  assign o_enable_ted = r_enable_ted;
  assign o_phase_sel  = r_phase;
  assign o_state      = r_state;
  assign o_locked     = r_locked;
  assign o_slip_adv   = r_slip_adv;
  assign o_slip_ret   = r_slip_ret;
  assign o_loop_out   = r_loop_out;

endmodule

// File: tb/tb_ted_loop_ctrl.sv
// Testbench for ted_loop_ctrl with default parameters (OS=4, THRESH=2048).
module tb_ted_loop_ctrl;

  logic               clk;
  logic               rst_n;
  logic               i_start;
  logic               i_stop;
  logic               i_sample_valid;
  logic signed [18:0] i_ted;
  logic               i_ted_valid;
  logic               o_enable_ted;
  logic [1:0]         o_phase_sel;
  logic [1:0]         o_state;
  logic               o_locked;
  logic               o_slip_adv;
  logic               o_slip_ret;
  logic signed [23:0] o_loop_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int ted;
    int exp_out;
    bit exp_adv;
    bit exp_ret;
    int exp_ph;
  } vec_t;

  typedef struct {
    longint out;
    bit     adv;
    bit     ret;
    int     ph;
  } exp_t;

  vec_t   vecs[11];
  exp_t   sbq[$];
  longint m_integ;
  int     m_phase;

  ted_loop_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start        (i_start),
    .i_stop         (i_stop),
    .i_sample_valid (i_sample_valid),
    .i_ted          (i_ted),
    .i_ted_valid    (i_ted_valid),
    .o_enable_ted   (o_enable_ted),
    .o_phase_sel    (o_phase_sel),
    .o_state        (o_state),
    .o_locked       (o_locked),
    .o_slip_adv     (o_slip_adv),
    .o_slip_ret     (o_slip_ret),
    .o_loop_out     (o_loop_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Reference PI filter with saturation and slip, written from the loop equations.
  function automatic void mdl(input longint ted, input int kp, input int ki,
                              inout longint integ, output longint out,
                              output bit adv, output bit ret);
    longint mx;
    longint i2;
    mx = 64'sd8388607;
    i2 = integ + (ted >>> ki);
    if (i2 > mx) i2 = mx;
    if (i2 < -mx) i2 = -mx;
    out = (ted >>> kp) + i2;
    if (out > mx) out = mx;
    if (out < -mx) out = -mx;
    adv = (out > 2048);
    ret = (out < -2048);
    if (adv) i2 = i2 - 2048;
    if (ret) i2 = i2 + 2048;
    if (i2 > mx) i2 = mx;
    if (i2 < -mx) i2 = -mx;
    integ = i2;
  endfunction

  task automatic sb_check(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, " out"}, o_loop_out, e.out);
      chk({tag, " adv"}, o_slip_adv, e.adv);
      chk({tag, " ret"}, o_slip_ret, e.ret);
      chk({tag, " phase"}, o_phase_sel, e.ph);
    end
  endtask

  // Returns cycles until the next strobe; a missing strobe counts as a failure.
  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!o_enable_ted && n < 50);
    if (!o_enable_ted) chk("strobe timeout", o_enable_ted, 1);
  endtask

  initial begin
    int n;
    int gap;
    int nstb;
    int bad_gap;
    int bad_ph;
    int cyc;
    exp_t e;

    // ACQ gains from zero integrator: kp>>>4, ki>>>8, THRESH 2048
    vecs[0]  = '{0,      0,     1'b0, 1'b0, 0};
    vecs[1]  = '{16384,  1088,  1'b0, 1'b0, 0};
    vecs[2]  = '{65536,  4416,  1'b1, 1'b0, 1};
    vecs[3]  = '{-65536, -6080, 1'b0, 1'b1, 0};
    vecs[4]  = '{-1,     62,    1'b0, 1'b0, 0};
    vecs[5]  = '{-40000, -2594, 1'b0, 1'b1, 3};
    vecs[6]  = '{1000,   2019,  1'b0, 1'b0, 3};
    vecs[7]  = '{1600,   2063,  1'b1, 1'b0, 0};
    vecs[8]  = '{32128,  2048,  1'b0, 1'b0, 0};
    vecs[9]  = '{-31440, -2048, 1'b0, 1'b0, 0};
    vecs[10] = '{-16,    -85,   1'b0, 1'b0, 0};

    rst_n = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_sample_valid = 1'b0;
    i_ted = '0; i_ted_valid = 1'b0;
    tick(); tick();
    chk("rst state", o_state, 0);
    chk("rst loop_out", o_loop_out, 0);
    chk("rst enable", o_enable_ted, 0);
    chk("rst phase", o_phase_sel, 0);

    // IDLE ignores samples and TED error
    rst_n = 1'b1; i_sample_valid = 1'b1; i_ted = 19'sd65536; i_ted_valid = 1'b1;
    tick(); tick();
    chk("idle enable", o_enable_ted, 0);
    chk("idle loop_out", o_loop_out, 0);
    chk("idle slip", o_slip_adv, 0);
    i_ted_valid = 1'b0; i_sample_valid = 1'b0;

    // start with stop in IDLE stays IDLE
    i_start = 1'b1; i_stop = 1'b1;
    tick();
    chk("start+stop idle", o_state, 0);
    i_stop = 1'b0;
    tick();
    i_start = 1'b0;
    chk("start acq", o_state, 1);

    // filter vector table in ACQ
    for (int i = 0; i < 11; i++) begin
      i_ted = 19'(vecs[i].ted);
      i_ted_valid = 1'b1;
      e.out = vecs[i].exp_out; e.adv = vecs[i].exp_adv;
      e.ret = vecs[i].exp_ret; e.ph = vecs[i].exp_ph;
      sbq.push_back(e);
      tick();
      sb_check($sformatf("vec%0d", i));
    end
    i_ted_valid = 1'b0;
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    chk("stop to idle", o_state, 0);

    // single advance in ACQ from phase 0
    i_sample_valid = 1'b1; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_strobe(n);
    chk("first strobe latency", n, 1);
    i_ted = 19'sd65536; i_ted_valid = 1'b1;
    tick();
    i_ted_valid = 1'b0;
    chk("acq adv out", o_loop_out, 4352);
    chk("acq adv pulse", o_slip_adv, 1);
    chk("acq adv phase", o_phase_sel, 1);
    wait_strobe(n);
    chk("gap after adv", n + 1, 5);
    i_ted = 19'sd0; i_ted_valid = 1'b1;
    tick();
    i_ted_valid = 1'b0;
    chk("integ after adv", o_loop_out, -1792);
    chk("no slip at -1792", o_slip_ret, 0);
    wait_strobe(n);
    chk("nominal gap phase1", n + 1, 4);
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;

    // nominal run: ACQ to TRACK after 256 strobes, lock after 64 more
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    gap = 0; nstb = 0; bad_gap = 0; bad_ph = 0;
    for (int c = 0; c < 1200 && nstb < 256; c++) begin
      tick();
      gap++;
      if (o_phase_sel != 2'd0) bad_ph++;
      if (o_enable_ted) begin
        nstb++;
        if (nstb == 1 && gap != 1) bad_gap++;
        if (nstb > 1 && gap != 4) bad_gap++;
        if (nstb == 255) chk("acq before last strobe", o_state, 1);
        gap = 0;
      end
    end
    chk("acq strobe count", nstb, 256);
    tick();
    gap++;
    chk("track entry", o_state, 2);
    nstb = 0;
    for (int c = 0; c < 400 && nstb < 64; c++) begin
      tick();
      gap++;
      if (o_phase_sel != 2'd0) bad_ph++;
      if (o_enable_ted) begin
        nstb++;
        if (gap != 4) bad_gap++;
        if (nstb == 63) chk("lock early", o_locked, 0);
        gap = 0;
      end
    end
    chk("track strobe count", nstb, 64);
    tick();
    chk("locked", o_locked, 1);
    chk("nominal gaps", bad_gap, 0);
    chk("nominal phase", bad_ph, 0);

    // retard 0 -> 3 in TRACK drops lock, gap 3
    wait_strobe(n);
    i_ted = 19'h40000; i_ted_valid = 1'b1;
    tick();
    i_ted_valid = 1'b0;
    chk("trk ret pulse", o_slip_ret, 1);
    chk("trk ret no adv", o_slip_adv, 0);
    chk("trk ret unlock", o_locked, 0);
    chk("trk ret phase", o_phase_sel, 3);
    chk("trk ret out", o_loop_out, -4160);
    wait_strobe(n);
    chk("gap after retard", n + 1, 3);

    // advance 3 -> 0 wraps, gap 5
    i_ted = 19'h3FFFF; i_ted_valid = 1'b1;
    tick();
    i_ted_valid = 1'b0;
    chk("wrap adv pulse", o_slip_adv, 1);
    chk("wrap adv phase", o_phase_sel, 0);
    chk("wrap adv out", o_loop_out, 6142);
    wait_strobe(n);
    chk("gap after wrap", n + 1, 5);

    // repeated full-scale error in TRACK against the reference filter
    m_integ = -1; m_phase = 0;
    for (int i = 0; i < 80; i++) begin
      i_ted = (i < 40) ? 19'h3FFFF : 19'h40000;
      i_ted_valid = 1'b1;
      mdl(longint'(i_ted), 6, 12, m_integ, e.out, e.adv, e.ret);
      if (e.adv) m_phase = (m_phase + 1) % 4;
      if (e.ret) m_phase = (m_phase + 3) % 4;
      e.ph = m_phase;
      sbq.push_back(e);
      tick();
      sb_check($sformatf("fs%0d", i));
    end
    i_ted_valid = 1'b0;

    // stop with TED update in the same cycle
    i_stop = 1'b1; i_ted = 19'h3FFFF; i_ted_valid = 1'b1;
    tick();
    i_stop = 1'b0; i_ted_valid = 1'b0;
    chk("stop state", o_state, 0);
    chk("stop no adv", o_slip_adv, 0);
    chk("stop no ret", o_slip_ret, 0);
    chk("stop phase", o_phase_sel, 0);
    chk("stop locked", o_locked, 0);

    // restart, reach TRACK, then reset mid-TRACK
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_ted = 19'sd0; i_ted_valid = 1'b1;
    tick();
    i_ted_valid = 1'b0;
    chk("restart integ zero", o_loop_out, 0);
    cyc = 0;
    while (o_state != 2'd2 && cyc < 1200) begin
      tick();
      cyc++;
    end
    chk("reach track", o_state, 2);
    i_ted = 19'sd1000; i_ted_valid = 1'b1;
    tick();
    i_ted_valid = 1'b0;
    chk("track gain out", o_loop_out, 15);
    for (int i = 0; i < 300; i++) tick();
    chk("locked before reset", o_locked, 1);
    rst_n = 1'b0;
    tick(); tick();
    chk("mid rst state", o_state, 0);
    chk("mid rst locked", o_locked, 0);
    chk("mid rst loop_out", o_loop_out, 0);
    chk("mid rst enable", o_enable_ted, 0);
    chk("mid rst phase", o_phase_sel, 0);
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
